// File: rtl/calc1_if.sv
`default_nettype none
// ============================================================================
// Module   : calc1_if
// Function : Request/response bundle for the four calc1_top channels.
// Revision : 1.0 - initial release
// ============================================================================
interface calc1_if;
    logic [0:3]  req1_cmd_in;
    logic [0:3]  req2_cmd_in;
    logic [0:3]  req3_cmd_in;
    logic [0:3]  req4_cmd_in;
    logic [0:31] req1_data_in;
    logic [0:31] req2_data_in;
    logic [0:31] req3_data_in;
    logic [0:31] req4_data_in;
    logic [0:31] out_data1;
    logic [0:31] out_data2;
    logic [0:31] out_data3;
    logic [0:31] out_data4;
    logic [0:1]  out_resp1;
    logic [0:1]  out_resp2;
    logic [0:1]  out_resp3;
    logic [0:1]  out_resp4;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  out_data1, out_data2, out_data3, out_data4,
        input  out_resp1, out_resp2, out_resp3, out_resp4
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output out_data1, out_data2, out_data3, out_data4,
        output out_resp1, out_resp2, out_resp3, out_resp4
    );
endinterface
`default_nettype wire

// File: rtl/calc1_top.sv
`default_nettype none
// ============================================================================
// Module   : calc1_top
// Function : Four independent 32-bit unsigned calculator channels (add/sub,
//            optional shl/shr when CALC1_SHIFT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module calc1_top (
    input  wire logic       c_clk,
    input  wire logic [1:7] reset,
    calc1_if.slave          bus
);

    localparam int N_CH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP2  = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
`ifdef CALC1_SHIFT_EN
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;
`endif

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    // Any reset bit high clears the whole block.
    logic rst_any;
    assign rst_any = |reset;

    logic [0:3]  cmd_in   [N_CH];
    logic [0:31] data_in  [N_CH];
    logic [0:31] res_data [N_CH];
    logic [0:1]  res_resp [N_CH];

    assign cmd_in[0]  = bus.req1_cmd_in;
    assign cmd_in[1]  = bus.req2_cmd_in;
    assign cmd_in[2]  = bus.req3_cmd_in;
    assign cmd_in[3]  = bus.req4_cmd_in;
    assign data_in[0] = bus.req1_data_in;
    assign data_in[1] = bus.req2_data_in;
    assign data_in[2] = bus.req3_data_in;
    assign data_in[3] = bus.req4_data_in;

    assign bus.out_data1 = res_data[0];
    assign bus.out_data2 = res_data[1];
    assign bus.out_data3 = res_data[2];
    assign bus.out_data4 = res_data[3];
    assign bus.out_resp1 = res_resp[0];
    assign bus.out_resp2 = res_resp[1];
    assign bus.out_resp3 = res_resp[2];
    assign bus.out_resp4 = res_resp[3];

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            logic [1:0]  state_q, state_d;
            logic [0:3]  cmd_q,   cmd_d;
            logic [0:31] op1_q,   op1_d;
            logic [0:31] op2_q,   op2_d;
            logic [0:31] data_q,  data_d;
            logic [0:1]  resp_q,  resp_d;
            logic        cmd_ok;
            logic [32:0] sum_w;

            assign sum_w = {1'b0, op1_q} + {1'b0, op2_q};

            always_comb begin
                cmd_ok = 1'b0;
                case (cmd_in[g])
                    CMD_ADD, CMD_SUB: cmd_ok = 1'b1;
`ifdef CALC1_SHIFT_EN
                    CMD_SHL, CMD_SHR: cmd_ok = 1'b1;
`endif
                    default:          cmd_ok = 1'b0;
                endcase
            end

            always_ff @(posedge c_clk or posedge rst_any) begin
                if (rst_any) begin
                    state_q <= ST_IDLE;
                    cmd_q   <= '0;
                    op1_q   <= '0;
                    op2_q   <= '0;
                    data_q  <= '0;
                    resp_q  <= RESP_NONE;
                end else begin
                    state_q <= state_d;
                    cmd_q   <= cmd_d;
                    op1_q   <= op1_d;
                    op2_q   <= op2_d;
                    data_q  <= data_d;
                    resp_q  <= resp_d;
                end
            end

            // Next state plus operand capture; non-IDLE states ignore cmd_in.
            always_comb begin
                state_d = state_q;
                cmd_d   = cmd_q;
                op1_d   = op1_q;
                op2_d   = op2_q;
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_ok) begin
                            state_d = ST_OP2;
                            cmd_d   = cmd_in[g];
                            op1_d   = data_in[g];
                        end else if (cmd_in[g] != 4'd0) begin
                            state_d = ST_ERR;
                        end
                    end
                    ST_OP2: begin
                        state_d = ST_EXEC;
                        op2_d   = data_in[g];
                    end
                    ST_EXEC: state_d = ST_IDLE;
                    ST_ERR:  state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end

            // Result words are pulses: zero unless this cycle closes an op.
            always_comb begin
                resp_d = RESP_NONE;
                data_d = '0;
                case (state_q)
                    ST_EXEC: begin
                        case (cmd_q)
                            CMD_ADD: begin
                                if (sum_w[32]) begin
                                    resp_d = RESP_ERR;
                                end else begin
                                    resp_d = RESP_OK;
                                    data_d = sum_w[31:0];
                                end
                            end
                            CMD_SUB: begin
                                if (op2_q > op1_q) begin
                                    resp_d = RESP_ERR;
                                end else begin
                                    resp_d = RESP_OK;
                                    data_d = op1_q - op2_q;
                                end
                            end
`ifdef CALC1_SHIFT_EN
                            CMD_SHL: begin
                                resp_d = RESP_OK;
                                data_d = op1_q << op2_q[27:31];
                            end
                            CMD_SHR: begin
                                resp_d = RESP_OK;
                                data_d = op1_q >> op2_q[27:31];
                            end
`endif
                            default: resp_d = RESP_ERR;
                        endcase
                    end
                    ST_ERR:  resp_d = RESP_ERR;
                    default: resp_d = RESP_NONE;
                endcase
            end

            assign res_data[g] = data_q;
            assign res_resp[g] = resp_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_calc1_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc1_top
// Function : Directed scoreboard bench for calc1_top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc1_top;

    typedef struct {
        int          port;
        int          due;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic       clk;
    logic [1:7] rst_v;
    int         cyc;
    int         total;
    int         bad;
    exp_t       sb[$];

    calc1_if bus ();

    calc1_top dut (
        .c_clk (clk),
        .reset (rst_v),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_valid(input logic [3:0] c);
        if (c == 4'd1 || c == 4'd2) return 1'b1;
`ifdef CALC1_SHIFT_EN
        if (c == 4'd5 || c == 4'd6) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] d);
        case (p)
            0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
            1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
            2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
            default: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
        endcase
    endtask

    task automatic expect_op(input int p, input logic [3:0] c,
                             input logic [31:0] a, input logic [31:0] b, input int issue);
        exp_t        e;
        logic [32:0] s;
        e.port = p;
        e.resp = 2'd2;
        e.data = 32'd0;
        e.due  = is_valid(c) ? issue + 3 : issue + 2;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (!s[32]) begin e.resp = 2'd1; e.data = s[31:0]; end
            end
            4'd2: if (b <= a) begin e.resp = 2'd1; e.data = a - b; end
`ifdef CALC1_SHIFT_EN
            4'd5: begin e.resp = 2'd1; e.data = a << b[4:0]; end
            4'd6: begin e.resp = 2'd1; e.data = a >> b[4:0]; end
`endif
            default: ;
        endcase
        sb.push_back(e);
    endtask

    // One clock, then compare every port against the scoreboard (0/0 if nothing due).
    task automatic step();
        logic [1:0]  er, orr;
        logic [31:0] ed, od;
        int          idx;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 4; p++) begin
            er = 2'd0; ed = 32'd0; idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].port == p && sb[i].due == cyc) idx = i;
            if (idx >= 0) begin
                er = sb[idx].resp;
                ed = sb[idx].data;
                sb.delete(idx);
            end
            case (p)
                0: begin orr = bus.out_resp1; od = bus.out_data1; end
                1: begin orr = bus.out_resp2; od = bus.out_data2; end
                2: begin orr = bus.out_resp3; od = bus.out_data3; end
                default: begin orr = bus.out_resp4; od = bus.out_data4; end
            endcase
            total++;
            assert (orr === er && od === ed) else begin
                bad++;
                $error("FAIL port%0d cyc%0d got resp=%0d data=%h want resp=%0d data=%h",
                       p + 1, cyc, orr, od, er, ed);
            end
        end
    endtask

    task automatic run_op(input int p, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        expect_op(p, c, a, b, cyc);
        set_req(p, c, a);
        step();
        if (is_valid(c)) begin
            set_req(p, 4'd0, b);
            step();
            set_req(p, 4'd0, 32'd0);
            step();
            step();
        end else begin
            set_req(p, 4'd0, 32'd0);
            step();
            step();
        end
    endtask

    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [31:0] x;

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst_v = 7'b1000000;
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 32'd0);

        // Reset held on reset[1], then released with idle inputs.
        for (int i = 0; i < 4; i++) step();
        rst_v = '0;
        for (int i = 0; i < 3; i++) step();

        run_op(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF);
        run_op(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
        run_op(0, 4'd1, 32'h0000_0000, 32'h0000_0000);
        run_op(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(0, 4'd2, 32'h0000_0001, 32'h0000_000F);
        run_op(0, 4'd2, 32'h0000_000F, 32'h0000_0001);
        run_op(0, 4'd2, 32'h1234_5678, 32'h1234_5678);
        run_op(0, 4'd3, 32'h0000_0001, 32'h0000_0000);
        run_op(0, 4'd4, 32'h0000_0001, 32'h0000_0000);
        run_op(2, 4'd15, 32'h0000_0001, 32'h0000_0000);
        run_op(1, 4'd2, 32'hFFFF_FFFF, 32'h0000_0001);

        for (int k = 0; k <= 30; k++) begin
            x = 32'd1 << k;
            run_op(0, 4'd1, x, 32'd0);
            if (k <= 29) run_op(0, 4'd5, x, 32'd1);
        end
        run_op(0, 4'd6, 32'h8000_0000, 32'd31);
        run_op(3, 4'd5, 32'hF000_000F, 32'hFFFF_FFE4);

        // All four ports issue adds on the same edge.
        ca[0] = 32'h0000_0010; cb[0] = 32'h0000_0020;
        ca[1] = 32'h7FFF_FFFF; cb[1] = 32'h7FFF_FFFF;
        ca[2] = 32'hFFFF_FFF0; cb[2] = 32'h0000_0020;
        ca[3] = 32'h0ABC_0000; cb[3] = 32'h0000_0DEF;
        for (int p = 0; p < 4; p++) begin
            expect_op(p, 4'd1, ca[p], cb[p], cyc);
            set_req(p, 4'd1, ca[p]);
        end
        step();
        for (int p = 0; p < 4; p++) set_req(p, 4'd1, cb[p]);
        step();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 32'd0);
        step();
        step();

        // Reset pulsed while port1 sits in OP2: no response may follow.
        set_req(0, 4'd1, 32'h0000_0005);
        step();
        set_req(0, 4'd0, 32'h0000_0006);
        rst_v = 7'b0010000;
        #1;
        step();
        rst_v = '0;
        set_req(0, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) step();

        // Channel recovered after the abort.
        run_op(0, 4'd1, 32'h0000_0002, 32'h0000_0003);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
